// File: rtl/bicg_pkg.sv
// Shared definitions for the BiCG activity benchmark.
//   state_e      : kernel sequencing states
//   N/M/DW_DEF   : default problem size and datapath width
//   nibble_fold  : XOR of all 4-bit nibbles of a DW_DEF-bit word
package bicg_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned M_DEF  = 4;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    EMIT_S  = 2'd2,
    RESTART = 2'd3
  } state_e;

  // Collapse a word onto 4 bits so every result bit reaches a pin.
  function automatic logic [3:0] nibble_fold(input logic [DW_DEF-1:0] w);
    logic [3:0] f;
    f = 4'h0;
    for (int unsigned n = 0; n < DW_DEF / 4; n++) begin
      f = f ^ w[4*n +: 4];
    end
    return f;
  endfunction

endpackage

// File: rtl/bicg_core.sv
// BiCG kernel: s = A^T*r and q = A*p with operands generated from indices.
//   clk_i          : kernel clock
//   rst_i          : synchronous active-high reset
//   s_out_write_o  : one-cycle strobe per emitted s word
//   s_out_din_o    : s word (valid with strobe)
//   q_out_write_o  : one-cycle strobe per finished q row
//   q_out_din_o    : q word (valid with strobe)
module bicg_core
  import bicg_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned M  = M_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          s_out_write_o,
  output logic [DW-1:0] s_out_din_o,
  output logic          q_out_write_o,
  output logic [DW-1:0] q_out_din_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned JW = (M > 1) ? $clog2(M) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [JW-1:0]   k_q, k_d;
  logic [DW-1:0]   s_acc_q [M];
  logic [DW-1:0]   s_acc_d [M];
  logic [DW-1:0]   q_acc_q, q_acc_d;
  logic            s_out_write_q, s_out_write_d;
  logic [DW-1:0]   s_out_din_q, s_out_din_d;
  logic            q_out_write_q, q_out_write_d;
  logic [DW-1:0]   q_out_din_q, q_out_din_d;

  // Closed-form operands for the current (i,j); products truncate to DW.
  logic [DW-1:0] a_ij, r_i, p_j, prod_s, prod_q, q_sum;

  assign a_ij   = DW'(i_q) * DW'(M) + DW'(j_q) + DW'(1);
  assign r_i    = DW'(i_q) + DW'(1);
  assign p_j    = DW'(j_q) + DW'(1);
  assign prod_s = r_i * a_ij;
  assign prod_q = a_ij * p_j;
  assign q_sum  = q_acc_q + prod_q;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      q_acc_q       <= '0;
      s_out_write_q <= 1'b0;
      s_out_din_q   <= '0;
      q_out_write_q <= 1'b0;
      q_out_din_q   <= '0;
      for (int unsigned n = 0; n < M; n++) s_acc_q[n] <= '0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      q_acc_q       <= q_acc_d;
      s_out_write_q <= s_out_write_d;
      s_out_din_q   <= s_out_din_d;
      q_out_write_q <= q_out_write_d;
      q_out_din_q   <= q_out_din_d;
      for (int unsigned n = 0; n < M; n++) s_acc_q[n] <= s_acc_d[n];
    end
  end

  // Next-state, MAC updates and write strobes.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    q_acc_d       = q_acc_q;
    s_acc_d       = s_acc_q;
    s_out_write_d = 1'b0;
    s_out_din_d   = s_out_din_q;
    q_out_write_d = 1'b0;
    q_out_din_d   = q_out_din_q;

    unique case (state_q)
      IDLE: begin
        state_d = CALC;
      end

      CALC: begin
        s_acc_d[j_q] = s_acc_q[j_q] + prod_s;
        if (j_q == JW'(M - 1)) begin
          // Row done: publish the completed dot product and start the next row.
          q_out_din_d   = q_sum;
          q_out_write_d = 1'b1;
          q_acc_d       = '0;
          j_d           = '0;
          if (i_q == IW'(N - 1)) begin
            i_d     = '0;
            k_d     = '0;
            state_d = EMIT_S;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          q_acc_d = q_sum;
          j_d     = j_q + JW'(1);
        end
      end

      EMIT_S: begin
        s_out_din_d   = s_acc_q[k_q];
        s_out_write_d = 1'b1;
        if (k_q == JW'(M - 1)) begin
          k_d     = '0;
          state_d = RESTART;
        end else begin
          k_d = k_q + JW'(1);
        end
      end

      RESTART: begin
        for (int unsigned n = 0; n < M; n++) s_acc_d[n] = '0;
        q_acc_d = '0;
        i_d     = '0;
        j_d     = '0;
        state_d = CALC;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_out_write_o = s_out_write_q;
  assign s_out_din_o   = s_out_din_q;
  assign q_out_write_o = q_out_write_q;
  assign q_out_din_o   = q_out_din_q;

endmodule

// File: rtl/bicg_io_wrapper.sv
// Board-level wrapper: differential clock in, BiCG kernel, results folded to pins.
//   clk_p/clk_n : differential clock legs
//   ap_rst      : synchronous active-high reset on ap_clk
//   probe_out   : running parity of all emitted result words
//   data_out    : nibble-fold of the result word(s) written last cycle
//   data_valid  : high one cycle after any result write
module bicg_io_wrapper
  import bicg_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned M  = M_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic       clk_p,
  input  logic       clk_n,
  input  logic       ap_rst,
  output logic       probe_out,
  output logic [3:0] data_out,
  output logic       data_valid
);

  // Behavioural differential receiver: high when the legs read 1/0.
  logic ap_clk;
  assign ap_clk = clk_p & ~clk_n;

  logic          s_out_write;
  logic [DW-1:0] s_out_din;
  logic          q_out_write;
  logic [DW-1:0] q_out_din;

  bicg_core #(
    .N  (N),
    .M  (M),
    .DW (DW)
  ) u_core (
    .clk_i         (ap_clk),
    .rst_i         (ap_rst),
    .s_out_write_o (s_out_write),
    .s_out_din_o   (s_out_din),
    .q_out_write_o (q_out_write),
    .q_out_din_o   (q_out_din)
  );

  // Merge both write ports into one word; idle ports contribute zero.
  logic [DW-1:0] w_c;
  assign w_c = (s_out_write ? s_out_din : '0) ^ (q_out_write ? q_out_din : '0);

  logic       probe_q, probe_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = nibble_fold(DW_DEF'(w_c));
    valid_d = s_out_write | q_out_write;
    probe_d = probe_q ^ (^w_c);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      probe_q <= 1'b0;
      data_q  <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      probe_q <= probe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign probe_out  = probe_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_bicg_io_wrapper.sv
// Directed bench for bicg_io_wrapper: reset, three frames, mid-CALC reset.
module tb_bicg_io_wrapper;

  logic       clk_p  = 1'b0;
  logic       clk_n  = 1'b1;
  logic       ap_rst = 1'b1;
  logic       probe_out;
  logic [3:0] data_out;
  logic       data_valid;

  int checks = 0;
  int errors = 0;

  // Hand-computed results for N=M=4 with their folds and parities.
  logic [31:0] q_exp   [4] = '{32'h1e, 32'h46, 32'h6e, 32'h96};
  logic [31:0] s_exp   [4] = '{32'h5a, 32'h64, 32'h6e, 32'h78};
  logic [3:0]  q_fold  [4] = '{4'hf, 4'h2, 4'h8, 4'hf};
  logic [3:0]  s_fold  [4] = '{4'hf, 4'h2, 4'h8, 4'hf};
  logic        q_par   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic        s_par   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  // Fold-stage expectations carried from the previous edge.
  logic       pend_valid = 1'b0;
  logic [3:0] pend_fold  = 4'h0;
  logic       pend_par   = 1'b0;
  logic       probe_exp  = 1'b0;

  always #5 begin
    clk_p = ~clk_p;
    clk_n = ~clk_n;
  end

  bicg_io_wrapper dut (
    .clk_p      (clk_p),
    .clk_n      (clk_n),
    .ap_rst     (ap_rst),
    .probe_out  (probe_out),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_qwr"},   32'(dut.q_out_write), 32'h0);
    chk({tag, "_swr"},   32'(dut.s_out_write), 32'h0);
    chk({tag, "_qdin"},  dut.q_out_din,        32'h0);
    chk({tag, "_sdin"},  dut.s_out_din,        32'h0);
    chk({tag, "_dout"},  32'(data_out),        32'h0);
    chk({tag, "_valid"}, 32'(data_valid),      32'h0);
    chk({tag, "_probe"}, 32'(probe_out),       32'h0);
  endtask

  // Advance one edge (n-th after reset release) and check it against the schedule.
  // Within a 21-edge period: q writes after edges 5,9,13,17; s writes after 18..21.
  task automatic step(input int n);
    int  m;
    logic eq, es;
    int  qi, si;
    tick();
    probe_exp = probe_exp ^ pend_par;
    chk("data_valid", 32'(data_valid), 32'(pend_valid));
    chk("data_out",   32'(data_out),   32'(pend_fold));
    chk("probe_out",  32'(probe_out),  32'(probe_exp));

    m  = ((n - 1) % 21) + 1;
    eq = (m >= 5) && (m <= 17) && (((m - 5) % 4) == 0);
    es = (m >= 18);
    qi = (m - 5) / 4;
    si = m - 18;
    chk("q_out_write", 32'(dut.q_out_write), 32'(eq));
    chk("s_out_write", 32'(dut.s_out_write), 32'(es));
    pend_valid = 1'b0;
    pend_fold  = 4'h0;
    pend_par   = 1'b0;
    if (eq) begin
      chk("q_out_din", dut.q_out_din, q_exp[qi]);
      pend_valid = 1'b1;
      pend_fold  = q_fold[qi];
      pend_par   = q_par[qi];
    end
    if (es) begin
      chk("s_out_din", dut.s_out_din, s_exp[si]);
      pend_valid = 1'b1;
      pend_fold  = s_fold[si];
      pend_par   = s_par[si];
    end
  endtask

  initial begin
    // Reset held for 100 ns: nothing may be written, all outputs low.
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c >= 1) begin
        chk("rst_qwr",   32'(dut.q_out_write), 32'h0);
        chk("rst_swr",   32'(dut.s_out_write), 32'h0);
      end
    end
    chk_all_zero("reset");
    ap_rst = 1'b0;

    // Three continuous frames.
    for (int n = 1; n <= 63; n++) step(n);

    // Into the fourth frame, past the first q write, then a one-cycle reset.
    for (int n = 64; n <= 71; n++) step(n);
    ap_rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    ap_rst = 1'b0;
    pend_valid = 1'b0;
    pend_fold  = 4'h0;
    pend_par   = 1'b0;
    probe_exp  = 1'b0;

    // Fresh frame must reproduce the sequence from the start.
    for (int n = 1; n <= 22; n++) step(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
